tx_frame_reader: RTL and testbench

Consumes the committed write address delivered by the TX write-address synchroniser in the MAC clock domain. It reads complete frames from the 1024×64-bit TX packet buffer and streams them to the 10G MAC transmit interface. It then returns its own committed read address so the host side can reclaim buffer space. Each frame in the buffer is one header word followed by its data words; everything below the committed write address is whole frames.

---
 rtl/tx_frame_reader.sv | 171 +++++++++++++++++
 tb/tb_tx_frame_reader.sv | 513 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_reader.sv
// tx_frame_reader: streams whole frames from the TX packet buffer to the
// 10G MAC and hands back the committed read address for buffer reclaim.
module tx_frame_reader #(
  parameter int MAX_LEN = 1536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  commited_wr_addr,
  output logic [9:0]  rd_addr,
  input  logic [63:0] rd_data,
  output logic [63:0] tx_data,
  output logic [7:0]  tx_keep,
  output logic        tx_last,
  output logic        tx_valid,
  input  logic        tx_ack,
  output logic [9:0]  commited_rd_addr,
  output logic        bad_len
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    FIRST,
    WAIT_ACK,
    STREAM
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [9:0]  rd_ptr;
  logic [2:0]  len_lo;
  logic [13:0] nwords;
  logic [13:0] widx;

  logic [15:0] hdr_len;
  logic [13:0] hdr_n;
  logic [9:0]  pending;
  logic        hdr_bad;
  logic        frame_end;
  logic [7:0]  mask;
  logic [9:0]  end_ptr;

  assign hdr_len = rd_data[15:0];
  assign hdr_n   = 14'(({1'b0, hdr_len} + 17'd7) >> 3);
  assign pending = commited_wr_addr - rd_ptr;

  // A frame that does not fit in what is committed is treated as corrupt.
  assign hdr_bad = (hdr_len == 16'd0)
                || ({16'd0, hdr_len} > 32'(MAX_LEN))
                || (({1'b0, hdr_n} + 15'd1) > {5'd0, pending});

  assign mask = (len_lo == 3'd0) ? 8'hFF
              : ((8'd1 << len_lo) - 8'd1);

  assign end_ptr = rd_ptr + 10'd1 + nwords[9:0];

  assign frame_end = tx_last
                  && (((state == WAIT_ACK) && tx_ack)
                   || (state == STREAM));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pending != 10'd0) state_nxt = HDR;
      end
      HDR: begin
        state_nxt = hdr_bad ? IDLE : FIRST;
      end
      FIRST: begin
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (tx_ack) begin
          state_nxt = (nwords == 14'd1) ? IDLE : STREAM;
        end
      end
      STREAM: begin
        if (tx_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer reads run one word ahead of tx_data.
  always_comb begin
    rd_addr = rd_ptr;
    unique case (state)
      HDR:      rd_addr = rd_ptr + 10'd1;
      FIRST:    rd_addr = rd_ptr + 10'd2;
      WAIT_ACK: rd_addr = rd_ptr + (tx_ack ? 10'd3 : 10'd2);
      STREAM:   rd_addr = rd_ptr + widx[9:0] + 10'd3;
      default:  rd_addr = rd_ptr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr           <= '0;
      len_lo           <= '0;
      nwords           <= '0;
      widx             <= '0;
      tx_data          <= '0;
      tx_keep          <= '0;
      tx_last          <= 1'b0;
      tx_valid         <= 1'b0;
      commited_rd_addr <= '0;
      bad_len          <= 1'b0;
    end else begin
      bad_len <= 1'b0;
      unique case (state)
        HDR: begin
          len_lo <= hdr_len[2:0];
          nwords <= hdr_n;
          if (hdr_bad) begin
            bad_len          <= 1'b1;
            rd_ptr           <= commited_wr_addr;
            commited_rd_addr <= commited_wr_addr;
          end
        end
        FIRST: begin
          tx_data  <= rd_data;
          tx_valid <= 1'b1;
          widx     <= '0;
          if (nwords == 14'd1) begin
            tx_last <= 1'b1;
            tx_keep <= mask;
          end
        end
        WAIT_ACK: begin
          if (tx_ack && (nwords != 14'd1)) begin
            tx_data <= rd_data;
            widx    <= 14'd1;
            if (nwords == 14'd2) begin
              tx_last <= 1'b1;
              tx_keep <= mask;
            end
          end
        end
        STREAM: begin
          if (!tx_last) begin
            tx_data <= rd_data;
            widx    <= widx + 14'd1;
            if ((widx + 14'd2) == nwords) begin
              tx_last <= 1'b1;
              tx_keep <= mask;
            end
          end
        end
        default: ;
      endcase
      if (frame_end) begin
        tx_valid         <= 1'b0;
        tx_last          <= 1'b0;
        tx_keep          <= '0;
        rd_ptr           <= end_ptr;
        commited_rd_addr <= end_ptr;
      end
    end
  end

endmodule

// File: tb/tb_tx_frame_reader.sv
// Bench for tx_frame_reader: buffer model, MAC model with ack,
// and a frame-walking reference model of the buffer contents.
module tb_tx_frame_reader;

  localparam int MAX_LEN = 1536;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  commited_wr_addr;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [63:0] tx_data;
  logic [7:0]  tx_keep;
  logic        tx_last;
  logic        tx_valid;
  logic        tx_ack = 1'b0;
  logic [9:0]  commited_rd_addr;
  logic        bad_len;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [63:0] mem [1024];

  tx_frame_reader #(.MAX_LEN(MAX_LEN)) dut (
    .clk              (clk),
    .reset            (reset),
    .commited_wr_addr (commited_wr_addr),
    .rd_addr          (rd_addr),
    .rd_data          (rd_data),
    .tx_data          (tx_data),
    .tx_keep          (tx_keep),
    .tx_last          (tx_last),
    .tx_valid         (tx_valid),
    .tx_ack           (tx_ack),
    .commited_rd_addr (commited_rd_addr),
    .bad_len          (bad_len)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_data <= mem[rd_addr];

  // MAC model / monitor state
  int ack_delay = 0;
  bit noise = 1'b0;
  int clr_gen = 0;
  int clr_seen = 0;
  int clr_seen_w = 0;
  bit in_frame = 1'b0;
  bit acked = 1'b0;
  bit crd_pend = 1'b0;
  int wcnt = 0;
  logic [63:0] first_word;
  logic [63:0] cur[$];
  logic [63:0] obs_words[$];
  logic [7:0]  obs_keep[$];
  logic [9:0]  obs_crd[$];
  int rise_cyc[$];
  int ack_cyc[$];
  int last_cyc[$];
  int bad_cyc[$];
  bit first_last[$];
  int held_err = 0;
  int abandoned = 0;
  bit wrap_seen = 1'b0;
  logic [9:0] prev_ra = '0;

  always @(negedge clk) begin
    if (clr_seen != clr_gen) begin
      clr_seen = clr_gen;
      obs_words.delete();
      obs_keep.delete();
      obs_crd.delete();
      rise_cyc.delete();
      ack_cyc.delete();
      last_cyc.delete();
      bad_cyc.delete();
      first_last.delete();
      held_err = 0;
      abandoned = 0;
    end
    if (crd_pend) begin
      obs_crd.push_back(commited_rd_addr);
      crd_pend = 1'b0;
    end
    if (bad_len === 1'b1) bad_cyc.push_back(cyc);
    if (in_frame && tx_valid !== 1'b1) begin
      abandoned++;
      in_frame = 1'b0;
    end
    tx_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    if (tx_valid === 1'b1) begin
      if (!in_frame) begin
        in_frame = 1'b1;
        acked = 1'b0;
        wcnt = 0;
        cur.delete();
        first_word = tx_data;
        rise_cyc.push_back(cyc);
        first_last.push_back(tx_last);
      end
      if (!acked) begin
        if (tx_data !== first_word) held_err++;
        if (wcnt >= ack_delay) begin
          tx_ack = 1'b1;
          acked = 1'b1;
          ack_cyc.push_back(cyc);
        end else begin
          tx_ack = 1'b0;
          wcnt++;
        end
      end
      if (acked) begin
        cur.push_back(tx_data);
        if (tx_last === 1'b1) begin
          foreach (cur[i]) obs_words.push_back(cur[i]);
          obs_keep.push_back(tx_keep);
          last_cyc.push_back(cyc);
          crd_pend = 1'b1;
          in_frame = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    #1;
    if (clr_seen_w != clr_gen) begin
      clr_seen_w = clr_gen;
      wrap_seen = 1'b0;
    end
    if (prev_ra == 10'd1023 && rd_addr == 10'd0) wrap_seen = 1'b1;
    prev_ra = rd_addr;
  end

  // Reference model: walk the committed region frame by frame
  logic [63:0] exp_words[$];
  logic [7:0]  exp_keep[$];
  logic [9:0]  exp_crd[$];
  int exp_bad;
  int exp_frames;

  task automatic model(input int start, input int wr, output int fin);
    int p, len, n, pend, bytes;
    exp_words.delete();
    exp_keep.delete();
    exp_crd.delete();
    exp_bad = 0;
    exp_frames = 0;
    p = start;
    while (p != wr) begin
      len = int'(mem[p][15:0]);
      n = (len + 7) / 8;
      pend = (wr - p + 1024) % 1024;
      if (len == 0 || len > MAX_LEN || n + 1 > pend) begin
        exp_bad++;
        p = wr;
      end else begin
        for (int i = 0; i < n; i++) exp_words.push_back(mem[(p + 1 + i) % 1024]);
        bytes = len - 8 * (n - 1);
        exp_keep.push_back(8'((1 << bytes) - 1));
        p = (p + 1 + n) % 1024;
        exp_crd.push_back(10'(p));
        exp_frames++;
      end
    end
    fin = p;
  endtask

  function automatic int stream_diff();
    int d = 0;
    if (obs_words.size() != exp_words.size()) d++;
    else foreach (exp_words[i]) if (obs_words[i] !== exp_words[i]) d++;
    if (obs_keep.size() != exp_keep.size()) d++;
    else foreach (exp_keep[i]) if (obs_keep[i] !== exp_keep[i]) d++;
    if (obs_crd.size() != exp_crd.size()) d++;
    else foreach (exp_crd[i]) if (obs_crd[i] !== exp_crd[i]) d++;
    return d;
  endfunction

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic clear_obs();
    clr_gen++;
    step();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    commited_wr_addr = '0;
    repeat (2) step();
    reset = 1'b0;
    step();
  endtask

  task automatic put_frame(input int p, input int len, output int nxt);
    int n;
    mem[p] = {32'($urandom), 16'($urandom), 16'(len)};
    if (len >= 1 && len <= MAX_LEN) begin
      n = (len + 7) / 8;
      for (int i = 0; i < n; i++) mem[(p + 1 + i) % 1024] = {$urandom, $urandom};
      nxt = (p + 1 + n) % 1024;
    end else begin
      nxt = (p + 1) % 1024;
    end
  endtask

  task automatic settle(input int budget, output bit to);
    int k = 0;
    to = 1'b0;
    while (!(obs_keep.size() == exp_frames && bad_cyc.size() == exp_bad
             && !in_frame && !crd_pend)) begin
      step();
      k++;
      if (k >= budget) begin
        to = 1'b1;
        break;
      end
    end
    repeat (4) step();
  endtask

  task automatic test_reset();
    int vhi = 0;
    reset = 1'b1;
    commited_wr_addr = '0;
    repeat (3) step();
    checks++;
    if ({tx_data, tx_keep, tx_last, tx_valid, bad_len, commited_rd_addr, rd_addr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%h keep=%h last=%b valid=%b bad=%b crd=%0d ra=%0d required all 0",
               tx_data, tx_keep, tx_last, tx_valid, bad_len, commited_rd_addr, rd_addr);
    end
    reset = 1'b0;
    repeat (6) begin
      step();
      if (tx_valid !== 1'b0) vhi++;
    end
    checks++;
    if (vhi != 0 || rd_addr !== 10'd0) begin
      errors++;
      $display("FAIL reset_release: got valid_cycles=%0d ra=%0d required 0 and 0", vhi, rd_addr);
    end
  endtask

  task automatic test_frame64();
    int s, fin, nxt;
    bit to;
    do_reset();
    clear_obs();
    noise = 1'b0;
    ack_delay = 2;
    put_frame(0, 64, nxt);
    model(0, 9, fin);
    commited_wr_addr = 10'd9;
    s = cyc;
    settle(200, to);
    checks++;
    if (to) begin
      errors++;
      $display("FAIL f64_timeout: got timeout required completion");
    end
    checks++;
    if (rise_cyc.size() != 1 || rise_cyc[0] != s + 3) begin
      errors++;
      $display("FAIL f64_latency: got rise=%0d required %0d", rise_cyc.size() ? rise_cyc[0] : -1, s + 3);
    end
    checks++;
    if (ack_cyc.size() != 1 || last_cyc.size() != 1 || last_cyc[0] != ack_cyc[0] + 7) begin
      errors++;
      $display("FAIL f64_contiguous: got last=%0d required ack+7", last_cyc.size() ? last_cyc[0] : -1);
    end
    checks++;
    if (stream_diff() != 0) begin
      errors++;
      $display("FAIL f64_stream: got %0d diffs required 0", stream_diff());
    end
    checks++;
    if (obs_keep.size() != 1 || obs_keep[0] !== 8'hFF || first_last[0] !== 1'b0) begin
      errors++;
      $display("FAIL f64_keep: got keep=%h required ff", obs_keep.size() ? obs_keep[0] : 8'h00);
    end
    checks++;
    if (obs_crd.size() != 1 || obs_crd[0] !== 10'd9 || held_err != 0) begin
      errors++;
      $display("FAIL f64_crd: got crd=%0d held_err=%0d required 9 and 0",
               obs_crd.size() ? obs_crd[0] : 10'd0, held_err);
    end
  endtask

  task automatic test_short();
    int fin, nxt;
    bit to;
    do_reset();
    clear_obs();
    ack_delay = 1;
    put_frame(0, 61, nxt);
    model(0, 9, fin);
    commited_wr_addr = 10'd9;
    settle(200, to);
    checks++;
    if (to || stream_diff() != 0 || obs_keep.size() != 1 || obs_keep[0] !== 8'h1F) begin
      errors++;
      $display("FAIL len61: got keep=%h diffs=%0d to=%b required 1f 0 0",
               obs_keep.size() ? obs_keep[0] : 8'h00, stream_diff(), to);
    end
    do_reset();
    clear_obs();
    ack_delay = 3;
    put_frame(0, 8, nxt);
    model(0, 2, fin);
    commited_wr_addr = 10'd2;
    settle(200, to);
    checks++;
    if (to || stream_diff() != 0 || obs_words.size() != 1 || obs_keep[0] !== 8'hFF) begin
      errors++;
      $display("FAIL len8_stream: got words=%0d diffs=%0d required 1 0", obs_words.size(), stream_diff());
    end
    checks++;
    if (first_last.size() != 1 || first_last[0] !== 1'b1 || held_err != 0 || commited_rd_addr !== 10'd2) begin
      errors++;
      $display("FAIL len8_last: got first_last=%b held_err=%0d crd=%0d required 1 0 2",
               first_last.size() ? first_last[0] : 1'b0, held_err, commited_rd_addr);
    end
  endtask

  task automatic test_wrap();
    int fin, nxt;
    bit to;
    do_reset();
    clear_obs();
    ack_delay = 0;
    mem[0] = {48'h0, 16'd0};
    model(0, 1020, fin);
    commited_wr_addr = 10'd1020;
    settle(50, to);
    clear_obs();
    put_frame(1020, 60, nxt);
    model(1020, 5, fin);
    commited_wr_addr = 10'd5;
    settle(200, to);
    checks++;
    if (to || stream_diff() != 0 || obs_keep.size() != 1 || obs_keep[0] !== 8'h0F) begin
      errors++;
      $display("FAIL wrap_stream: got diffs=%0d to=%b required 0 0", stream_diff(), to);
    end
    checks++;
    if (commited_rd_addr !== 10'd5 || !wrap_seen) begin
      errors++;
      $display("FAIL wrap_addr: got crd=%0d wrap=%b required 5 1", commited_rd_addr, wrap_seen);
    end
  endtask

  task automatic test_bad();
    int lens[3] = '{0, 1600, 64};
    int wrs[3]  = '{12, 12, 5};
    int s, fin, nxt;
    bit to;
    for (int c = 0; c < 3; c++) begin
      do_reset();
      clear_obs();
      put_frame(0, lens[c], nxt);
      model(0, wrs[c], fin);
      commited_wr_addr = 10'(wrs[c]);
      s = cyc;
      settle(50, to);
      checks++;
      if (to || bad_cyc.size() != 1 || bad_cyc[0] != s + 2) begin
        errors++;
        $display("FAIL bad_pulse len=%0d: got pulses=%0d at=%0d required 1 at %0d",
                 lens[c], bad_cyc.size(), bad_cyc.size() ? bad_cyc[0] : -1, s + 2);
      end
      checks++;
      if (rise_cyc.size() != 0 || commited_rd_addr !== 10'(wrs[c])) begin
        errors++;
        $display("FAIL bad_flush len=%0d: got frames=%0d crd=%0d required 0 %0d",
                 lens[c], rise_cyc.size(), commited_rd_addr, wrs[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fin, nxt;
    bit to;
    do_reset();
    clear_obs();
    ack_delay = 1;
    put_frame(0, 64, nxt);
    put_frame(9, 64, nxt);
    model(0, 18, fin);
    commited_wr_addr = 10'd18;
    settle(400, to);
    checks++;
    if (to || stream_diff() != 0 || obs_crd.size() != 2 || obs_crd[0] !== 10'd9 || obs_crd[1] !== 10'd18) begin
      errors++;
      $display("FAIL b2b_stream: got diffs=%0d crds=%0d required 0 and 9,18", stream_diff(), obs_crd.size());
    end
    checks++;
    if (rise_cyc.size() != 2 || last_cyc.size() != 2 || rise_cyc[1] - last_cyc[0] != 4) begin
      errors++;
      $display("FAIL b2b_gap: got rise2-last1=%0d required 4",
               (rise_cyc.size() == 2 && last_cyc.size() >= 1) ? rise_cyc[1] - last_cyc[0] : -1);
    end
  endtask

  task automatic test_reset_mid();
    int fin, nxt, k;
    int vhi = 0;
    do_reset();
    clear_obs();
    ack_delay = 2;
    put_frame(0, 64, nxt);
    put_frame(9, 64, nxt);
    model(0, 18, fin);
    commited_wr_addr = 10'd18;
    k = 0;
    while (!(obs_keep.size() == 1 && in_frame && acked && cur.size() == 4) && k < 300) begin
      step();
      k++;
    end
    checks++;
    if (k >= 300) begin
      errors++;
      $display("FAIL rstmid_reach: got timeout required frame 2 word 3");
    end
    reset = 1'b1;
    commited_wr_addr = '0;
    step();
    checks++;
    if (tx_valid !== 1'b0 || commited_rd_addr !== 10'd0 || tx_last !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_state: got valid=%b crd=%0d last=%b required 0 0 0",
               tx_valid, commited_rd_addr, tx_last);
    end
    reset = 1'b0;
    repeat (8) begin
      step();
      if (tx_valid !== 1'b0) vhi++;
    end
    checks++;
    if (vhi != 0 || abandoned != 1) begin
      errors++;
      $display("FAIL rstmid_after: got valid_cycles=%0d abandoned=%0d required 0 1", vhi, abandoned);
    end
  endtask

  task automatic test_random();
    int p, q, wr, fin, nf, sel, len;
    bit to;
    do_reset();
    p = 0;
    noise = 1'b1;
    for (int r = 0; r < 25; r++) begin
      clear_obs();
      ack_delay = $urandom_range(0, 4);
      nf = $urandom_range(1, 4);
      q = p;
      for (int f = 0; f < nf; f++) begin
        sel = $urandom_range(0, 9);
        if (sel == 0) len = 0;
        else if (sel == 1) len = $urandom_range(MAX_LEN + 1, 4000);
        else if (sel == 2) len = $urandom_range(1, 16);
        else len = $urandom_range(1, MAX_LEN);
        put_frame(q, len, q);
      end
      wr = q;
      if ($urandom_range(0, 5) == 0) wr = (q + 1023) % 1024;
      model(p, wr, fin);
      commited_wr_addr = 10'(wr);
      settle(3000, to);
      checks++;
      if (to || stream_diff() != 0) begin
        errors++;
        $display("FAIL rand_stream r=%0d: got diffs=%0d to=%b required 0 0", r, stream_diff(), to);
      end
      checks++;
      if (bad_cyc.size() != exp_bad || commited_rd_addr !== 10'(fin)) begin
        errors++;
        $display("FAIL rand_ptr r=%0d: got bad=%0d crd=%0d required %0d %0d",
                 r, bad_cyc.size(), commited_rd_addr, exp_bad, fin);
      end
      checks++;
      if (held_err != 0 || abandoned != 0) begin
        errors++;
        $display("FAIL rand_hold r=%0d: got held_err=%0d abandoned=%0d required 0 0", r, held_err, abandoned);
      end
      p = fin;
    end
    noise = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1'b1;
    commited_wr_addr = '0;
    test_reset();
    test_frame64();
    test_short();
    test_wrap();
    test_bad();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
